forwarding_select_unit: RTL and testbench

- Pipelined control block that generates the select codes consumed by the EX-stage operand multiplexers: 3-input, 2-bit-select type, one per ALU operand.
- Tracks the destination register, write-enable and load flag of the instructions in EX and MEM.
- Compares them against the source registers of the instruction leaving ID and registers forwarding selects for the EX cycle.
- Raises a load-use stall and counts stall cycles.

---
 rtl/forwarding_select_unit_pkg.sv | 34 +++
 rtl/forwarding_select_unit_fwd_match_cmp.sv | 22 ++
 rtl/forwarding_select_unit.sv | 96 +++++++++
 tb/tb_forwarding_select_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/forwarding_select_unit_pkg.sv
// Shared types and constants for the EX-stage operand forwarding selector.
package forwarding_select_unit_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned FWD_SEL_W   = 2;

    typedef enum logic [FWD_SEL_W-1:0] {
        FWD_REGFILE = 2'b00,
        FWD_EXMEM   = 2'b01,
        FWD_MEMWB   = 2'b10
    } fwd_sel_e;

    // Pipeline tracking slot: destination, write-enable, load flag.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  ld;
    } slot_t;

    localparam slot_t BUBBLE_SLOT = '{rd: '0, we: 1'b0, ld: 1'b0};

    // Younger producer (EX) wins over the older one (MEM).
    function automatic fwd_sel_e pick_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_EXMEM;
        end
        if (mem_hit) begin
            return FWD_MEMWB;
        end
        return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/forwarding_select_unit_fwd_match_cmp.sv
// Per-operand comparator: flags a matching producer in the EX and MEM slots.
module fwd_match_cmp
    import forwarding_select_unit_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  src_use,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_we,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_we,
    output logic                  ex_hit_c,
    output logic                  mem_hit_c
);

    logic src_live;

    // x0 is hardwired zero, so it never takes a forwarded value.
    assign src_live  = src_use && (src != '0);
    assign ex_hit_c  = src_live && ex_we  && (ex_rd  == src);
    assign mem_hit_c = src_live && mem_we && (mem_rd == src);

endmodule

// File: rtl/forwarding_select_unit.sv
// Tracks EX/MEM producers, registers operand-mux selects for EX, raises load-use stall.
module forwarding_select_unit
    import forwarding_select_unit_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_use,
    input  logic                  id_rs2_use,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [FWD_SEL_W-1:0]  fwd_sel_a,
    output logic [FWD_SEL_W-1:0]  fwd_sel_b,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);

    slot_t    ex_slot;
    slot_t    mem_slot;
    slot_t    id_slot;
    fwd_sel_e sel_a_q;
    fwd_sel_e sel_b_q;

    logic a_ex_hit;
    logic a_mem_hit;
    logic b_ex_hit;
    logic b_mem_hit;
    logic advance;

    fwd_match_cmp u_cmp_a (
        .src       (id_rs1),
        .src_use   (id_rs1_use),
        .ex_rd     (ex_slot.rd),
        .ex_we     (ex_slot.we),
        .mem_rd    (mem_slot.rd),
        .mem_we    (mem_slot.we),
        .ex_hit_c  (a_ex_hit),
        .mem_hit_c (a_mem_hit)
    );

    fwd_match_cmp u_cmp_b (
        .src       (id_rs2),
        .src_use   (id_rs2_use),
        .ex_rd     (ex_slot.rd),
        .ex_we     (ex_slot.we),
        .mem_rd    (mem_slot.rd),
        .mem_we    (mem_slot.we),
        .ex_hit_c  (b_ex_hit),
        .mem_hit_c (b_mem_hit)
    );

    // Load result is not ready until MEM: hold the consumer one cycle.
    assign stall   = id_valid && !flush && ex_slot.ld && (a_ex_hit || b_ex_hit);
    assign advance = id_valid && !stall && !flush;
    assign id_slot = '{rd: id_rd, we: id_reg_write, ld: id_mem_read};

    // Slot pipeline and EX-cycle selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot  <= BUBBLE_SLOT;
            mem_slot <= BUBBLE_SLOT;
            sel_a_q  <= FWD_REGFILE;
            sel_b_q  <= FWD_REGFILE;
        end else begin
            mem_slot <= ex_slot;
            if (advance) begin
                ex_slot <= id_slot;
                sel_a_q <= pick_sel(a_ex_hit, a_mem_hit);
                sel_b_q <= pick_sel(b_ex_hit, b_mem_hit);
            end else begin
                ex_slot <= BUBBLE_SLOT;
                sel_a_q <= FWD_REGFILE;
                sel_b_q <= FWD_REGFILE;
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign fwd_sel_a = sel_a_q;
    assign fwd_sel_b = sel_b_q;

endmodule

// File: tb/tb_forwarding_select_unit.sv
// Directed vector bench for forwarding_select_unit, plus reset and saturation sequences.
module tb_forwarding_select_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_use;
    logic       id_rs2_use;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic       stall;
    logic [15:0] stall_count;
    logic [1:0] sat_sel_a;
    logic [1:0] sat_sel_b;
    logic       sat_stall;
    logic [7:0] sat_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       fl;
        logic       e_stall;
        logic [1:0] e_a;
        logic [1:0] e_b;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    forwarding_select_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_use   (id_rs1_use),
        .id_rs2_use   (id_rs2_use),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    forwarding_select_unit #(.CNT_W(8)) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_use   (id_rs1_use),
        .id_rs2_use   (id_rs2_use),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_sel_a    (sat_sel_a),
        .fwd_sel_b    (sat_sel_b),
        .stall        (sat_stall),
        .stall_count  (sat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl,
                       input logic es, input logic [1:0] ea, input logic [1:0] eb,
                       input logic [15:0] ec);
        vec_t t;
        t = '{v, rs1, u1, rs2, u2, rd, we, ld, fl, es, ea, eb, ec};
        vecs.push_back(t);
    endtask

    task automatic nop(input logic [15:0] ec);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ec);
    endtask

    task automatic drive(input vec_t t);
        id_valid     = t.v;
        id_rs1       = t.rs1;
        id_rs1_use   = t.u1;
        id_rs2       = t.rs2;
        id_rs2_use   = t.u2;
        id_rd        = t.rd;
        id_reg_write = t.we;
        id_mem_read  = t.ld;
        flush        = t.fl;
    endtask

    vec_t cur;

    initial begin
        rst_n = 1'b0;
        cur = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(cur);
        #3;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_sel_a", 32'(fwd_sel_a), 32'd0);
        chk("reset_sel_b", 32'(fwd_sel_b), 32'd0);
        chk("reset_cnt", 32'(stall_count), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // add x5,x1,x2 ; sub x6,x5,x3
        add(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        add(1, 5, 1, 3, 1, 6, 1, 0, 0, 0, 2'b01, 2'b00, 0);
        nop(0); nop(0);
        // add x5 ; and x8,x9,x10 ; or x7,x4,x5
        add(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        add(1, 9, 1, 10, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        add(1, 4, 1, 5, 1, 7, 1, 0, 0, 0, 2'b00, 2'b10, 0);
        nop(0); nop(0);
        // lw x5,0(x1) ; add x6,x5,x5 (stall once, then MEM forward)
        add(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        add(1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 2'b00, 2'b00, 1);
        add(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 2'b10, 2'b10, 1);
        nop(1); nop(1);
        // x0 never forwards ; addi x5 twice then use x5
        add(1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1);
        add(1, 0, 1, 0, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 1);
        add(1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00, 1);
        add(1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00, 1);
        add(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 2'b01, 2'b00, 1);
        nop(1); nop(1);
        // lw x0 ; add x6,x0,x2 : no stall
        add(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        add(1, 0, 1, 2, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00, 1);
        nop(1); nop(1);
        // lw x5 ; consumer flushed : no stall, bubble
        add(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        add(1, 5, 1, 5, 1, 6, 1, 0, 1, 0, 2'b00, 2'b00, 1);
        nop(1); nop(1);
        // lw x5 ; invalid ID slot reading x5 : no stall
        add(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        add(0, 5, 1, 5, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00, 1);
        nop(1); nop(1);
        // add x5 ; sub x6,x5,x3 flushed : selects 00
        add(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 1);
        add(1, 5, 1, 3, 1, 6, 1, 0, 1, 0, 2'b00, 2'b00, 1);
        nop(1); nop(1);
        // lw x5 ; add x6,x1,x5 : stall via operand B
        add(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        add(1, 1, 1, 5, 1, 6, 1, 0, 0, 1, 2'b00, 2'b00, 2);
        add(1, 1, 1, 5, 1, 6, 1, 0, 0, 0, 2'b00, 2'b10, 2);
        nop(2); nop(2);
        // lw x5 ; unrelated ; or x7,x5,x4 : MEM forward, no stall
        add(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 2);
        add(1, 9, 1, 10, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 2);
        add(1, 5, 1, 4, 1, 7, 1, 0, 0, 0, 2'b10, 2'b00, 2);
        nop(2); nop(2);
        // store-like (we=0) with rd=5 ; reader of x5 : no forward
        add(1, 1, 1, 5, 1, 5, 0, 0, 0, 0, 2'b00, 2'b00, 2);
        add(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 2'b00, 2'b00, 2);
        nop(2); nop(2);
        // add x5 ; add x6 ; add x7,x6,x5 : A from EX, B from MEM
        add(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 2);
        add(1, 1, 1, 2, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00, 2);
        add(1, 6, 1, 5, 1, 7, 1, 0, 0, 0, 2'b01, 2'b10, 2);
        nop(2); nop(2);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            @(posedge clk); #1;
            chk($sformatf("v%0d_sel_a", i), 32'(fwd_sel_a), 32'(vecs[i].e_a));
            chk($sformatf("v%0d_sel_b", i), 32'(fwd_sel_b), 32'(vecs[i].e_b));
            chk($sformatf("v%0d_cnt", i), 32'(stall_count), 32'(vecs[i].e_cnt));
        end

        // Asynchronous reset in the middle of a load-use stall.
        cur = '{1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0};
        drive(cur);
        @(posedge clk); #1;
        cur = '{1, 5, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0};
        drive(cur);
        @(posedge clk); #1;
        chk("pre_rst_sel_a", 32'(fwd_sel_a), 32'd1);
        cur = '{1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0};
        drive(cur);
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        chk("pre_rst_cnt", 32'(stall_count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_sel_a", 32'(fwd_sel_a), 32'd0);
        chk("rst_sel_b", 32'(fwd_sel_b), 32'd0);
        chk("rst_cnt", 32'(stall_count), 32'd0);
        chk("rst_sat_cnt", 32'(sat_count), 32'd0);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_sel_a", 32'(fwd_sel_a), 32'd0);
        chk("post_rst_sel_b", 32'(fwd_sel_b), 32'd0);
        chk("post_rst_cnt", 32'(stall_count), 32'd0);

        // Back-to-back lw x5,0(x5): every instruction stalls exactly once.
        cur = '{1, 5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0};
        drive(cur);
        for (int i = 0; i < 600; i++) begin
            #2;
            chk($sformatf("chain%0d_stall", i), 32'(stall), 32'(i % 2));
            @(posedge clk); #1;
        end
        chk("chain_cnt", 32'(stall_count), 32'd300);
        chk("sat_cnt_hold", 32'(sat_count), 32'hFF);
        cur = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(cur);
        #2;
        chk("drain_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("drain_cnt", 32'(stall_count), 32'd300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
